// File: rtl/jacaranda_imem_loader.sv
// jacaranda_imem_loader: wishbone program loader into jacaranda-8 imem; JACARANDA_LOADER_CSUM_EN adds a checksum reg at 0x10
module jacaranda_imem_loader #(
   parameter int          ADDR_W     = 8,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [7:0]        imem_data_o,
   output logic              cpu_rst_o,
   output logic              busy_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {S_LOAD, S_FLUSH, S_RUN} state_t;
   state_t state_q, state_d;
   logic ack_q, ack_d, we_q, we_d, cpu_rst_q, cpu_rst_d, load_q, load_d;
   logic ovf_q, ovf_d, err_q, err_d;
   logic [31:0] dat_q, dat_d, rdata, status, csum_rd;
   logic [ADDR_W-1:0] ptr_q, ptr_d, iaddr_q, iaddr_d;
   logic [7:0] idata_q, idata_d, off;
   logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [PW:0] cnt_q, cnt_d;
   logic [ADDR_W+7:0] mem_q [FIFO_DEPTH];
   logic [ADDR_W+7:0] mem_d [FIFO_DEPTH];
   logic [15:0] csum_q, csum_d;
   logic req, wr, hit, empty, full, drain, wr_ctrl, wr_data, wr_addr, clr, in_load, push;
   logic unused;
   assign unused = ^{wbs_sel_i, wbs_dat_i, csum_q};
   assign wbs_ack_o   = ack_q;
   assign wbs_dat_o   = dat_q;
   assign imem_we_o   = we_q;
   assign imem_addr_o = iaddr_q;
   assign imem_data_o = idata_q;
   assign cpu_rst_o   = cpu_rst_q;
   assign busy_o      = ~empty;
   // bus decode, register side effects, FIFO bookkeeping and state transitions
   always_comb begin
      hit     = wbs_adr_i[31:8] == BASE_ADDR[31:8];
      req     = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
      wr      = req & wbs_we_i;
      off     = wbs_adr_i[7:0];
      empty   = cnt_q == '0;
      full    = cnt_q == (PW+1)'(FIFO_DEPTH);
      drain   = state_q != S_RUN & ~empty;
      in_load = state_q == S_LOAD;
      wr_ctrl = wr & off == 8'h00;
      wr_data = wr & off == 8'h04 & wbs_sel_i[0];
      wr_addr = wr & off == 8'h0C;
      clr     = wr_ctrl & wbs_dat_i[1];
      push    = wr_data & in_load & ~full;
`ifdef JACARANDA_LOADER_CSUM_EN
      csum_d  = clr ? 16'h0 : we_q ? csum_q + 16'(idata_q) : csum_q;
      csum_rd = {16'h0, csum_q};
`else
      csum_d  = 16'h0;
      csum_rd = '0;
`endif
      status  = {16'h0, 8'(ptr_q), 3'b0, err_q, ovf_q, load_q, empty, full};
      rdata   = off == 8'h00 ? {31'h0, load_q} :
                off == 8'h08 ? status :
                off == 8'h0C ? 32'(ptr_q) :
                off == 8'h10 ? csum_rd : '0;
      ack_d   = req;
      dat_d   = req & ~wbs_we_i ? rdata : '0;
      state_d = wr_ctrl ? (wbs_dat_i[0] ? S_LOAD : in_load ? S_FLUSH : state_q) :
                (state_q == S_FLUSH & empty) ? S_RUN : state_q;
      load_d  = wr_ctrl ? wbs_dat_i[0] : load_q;
      cpu_rst_d = state_d != S_RUN;
      ptr_d   = clr ? '0 : wr_addr ? wbs_dat_i[ADDR_W-1:0] :
                (wr_data & in_load) ? ptr_q + ADDR_W'(1) : ptr_q;
      ovf_d   = ~clr & (ovf_q | (wr_data & in_load & full));
      err_d   = ~clr & (err_q | (wr_data & ~in_load));
      mem_d   = mem_q;
      if (push) mem_d[wp_q] = {ptr_q, wbs_dat_i[7:0]};
      wp_d    = push ? wp_q + PW'(1) : wp_q;
      rp_d    = drain ? rp_q + PW'(1) : rp_q;
      cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(drain);
      we_d    = drain;
      iaddr_d = drain ? mem_q[rp_q][ADDR_W+7:8] : iaddr_q;
      idata_d = drain ? mem_q[rp_q][7:0] : idata_q;
   end
   // all state and registered outputs
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q   <= S_LOAD;
         ack_q     <= 1'b0;
         dat_q     <= '0;
         we_q      <= 1'b0;
         iaddr_q   <= '0;
         idata_q   <= '0;
         cpu_rst_q <= 1'b1;
         load_q    <= 1'b1;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         ptr_q     <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         cnt_q     <= '0;
         csum_q    <= '0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
         we_q      <= we_d;
         iaddr_q   <= iaddr_d;
         idata_q   <= idata_d;
         cpu_rst_q <= cpu_rst_d;
         load_q    <= load_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
         ptr_q     <= ptr_d;
         wp_q      <= wp_d;
         rp_q      <= rp_d;
         cnt_q     <= cnt_d;
         mem_q     <= mem_d;
         csum_q    <= csum_d;
      end
   end
endmodule

// File: tb/tb_jacaranda_imem_loader.sv
// tb_jacaranda_imem_loader: directed self-checking bench for the imem loader
module tb_jacaranda_imem_loader;
   logic        clk = 1'b0, rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0;
   logic        ack, imem_we, cpu_rst, busy;
   logic [31:0] rdat;
   logic [7:0]  imem_addr, imem_data;
   int          tests = 0, fails = 0, n_log = 0;
   logic [7:0]  log_a [64];
   logic [7:0]  log_d [64];
   localparam logic [31:0] B = 32'h3000_0000;

   jacaranda_imem_loader dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
      .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_data_o(imem_data),
      .cpu_rst_o(cpu_rst), .busy_o(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (imem_we && n_log < 64) begin
      log_a[n_log] = imem_addr;
      log_d[n_log] = imem_data;
      n_log++;
   end

   task automatic bus(input logic w, input logic [7:0] off, input logic [31:0] d, output logic [31:0] q);
      int k;
      cyc = 1'b1; stb = 1'b1; we = w; sel = 4'hF; adr = B | 32'(off); wdat = d;
      k = 0;
      do begin @(negedge clk); k++; end while (!ack && k < 8);
      q = rdat;
      tests++;
      if (!ack) begin fails++; $display("FAIL ack_timeout off=%h ack=%b want 1", off, ack); end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d);
      logic [31:0] q;
      bus(1'b1, off, d, q);
   endtask

   task automatic rd(input logic [7:0] off, output logic [31:0] q);
      bus(1'b0, off, '0, q);
   endtask

   task automatic test_reset;
      logic [31:0] q;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if ({ack, rdat, imem_we, imem_addr, imem_data, busy} !== '0) begin
         fails++; $display("FAIL reset_outputs got ack=%b dat=%h we=%b a=%h d=%h busy=%b want all 0", ack, rdat, imem_we, imem_addr, imem_data, busy);
      end
      tests++;
      if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
      rst = 1'b0;
      @(negedge clk);
      rd(8'h08, q);
      tests++;
      if (q !== 32'h0000_0006) begin fails++; $display("FAIL reset_status got %h want 00000006", q); end
      repeat (3) @(negedge clk);
      tests++;
      if (n_log !== 0 || cpu_rst !== 1'b1) begin fails++; $display("FAIL reset_idle got writes=%0d cpu_rst=%b want 0,1", n_log, cpu_rst); end
   endtask

   task automatic test_ack_timing;
      logic [31:0] q;
      bit seen;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = B; sel = 4'hF;
      @(negedge clk);
      tests++;
      if (ack !== 1'b1 || rdat !== 32'h1) begin fails++; $display("FAIL ack_one_cycle got ack=%b dat=%h want 1,00000001", ack, rdat); end
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);
      tests++;
      if (ack !== 1'b0) begin fails++; $display("FAIL ack_pulse got %b want 0", ack); end
      cyc = 1'b1; stb = 1'b1; adr = B + 32'h100;
      seen = 1'b0;
      repeat (5) begin @(negedge clk); seen |= ack; end
      cyc = 1'b0; stb = 1'b0;
      tests++;
      if (seen) begin fails++; $display("FAIL off_window_ack got 1 want 0"); end
      @(negedge clk);
      rd(8'h20, q);
      tests++;
      if (q !== 32'h0) begin fails++; $display("FAIL other_offset got %h want 0", q); end
   endtask

   task automatic test_sequential;
      logic [31:0] q;
      int base;
      base = n_log;
      wr(8'h0C, 32'h10);
      wr(8'h04, 32'hA5);
      tests++;
      if (imem_we !== 1'b0) begin fails++; $display("FAIL latency_early got we=%b want 0", imem_we); end
      @(negedge clk);
      tests++;
      if (imem_we !== 1'b1 || imem_addr !== 8'h10 || imem_data !== 8'hA5) begin
         fails++; $display("FAIL latency_first got we=%b a=%h d=%h want 1,10,a5", imem_we, imem_addr, imem_data);
      end
      wr(8'h04, 32'h5A);
      wr(8'h04, 32'h3C);
      repeat (4) @(negedge clk);
      tests++;
      if (n_log - base !== 3 || log_a[base] !== 8'h10 || log_d[base] !== 8'hA5 || log_a[base+1] !== 8'h11 ||
          log_d[base+1] !== 8'h5A || log_a[base+2] !== 8'h12 || log_d[base+2] !== 8'h3C) begin
         fails++; $display("FAIL seq_writes got n=%0d first=(%h,%h) last=(%h,%h) want 3,(10,a5),(12,3c)",
                           n_log - base, log_a[base], log_d[base], log_a[base+2], log_d[base+2]);
      end
      rd(8'h0C, q);
      tests++;
      if (q !== 32'h13) begin fails++; $display("FAIL seq_ptr got %h want 00000013", q); end
      rd(8'h08, q);
      tests++;
      if (q !== 32'h0000_1306) begin fails++; $display("FAIL seq_status got %h want 00001306", q); end
   endtask

   task automatic test_wrap;
      logic [31:0] q;
      int base;
      base = n_log;
      wr(8'h0C, 32'hFF);
      wr(8'h04, 32'h11);
      wr(8'h04, 32'h22);
      repeat (4) @(negedge clk);
      tests++;
      if (n_log - base !== 2 || log_a[base] !== 8'hFF || log_d[base] !== 8'h11 || log_a[base+1] !== 8'h00 || log_d[base+1] !== 8'h22) begin
         fails++; $display("FAIL wrap_writes got n=%0d (%h,%h) (%h,%h) want 2,(ff,11),(00,22)",
                           n_log - base, log_a[base], log_d[base], log_a[base+1], log_d[base+1]);
      end
      rd(8'h0C, q);
      tests++;
      if (q !== 32'h1) begin fails++; $display("FAIL wrap_ptr got %h want 00000001", q); end
   endtask

   task automatic test_back_to_back;
      logic [31:0] q;
      int base, bad;
      base = n_log;
      bad = 0;
      wr(8'h0C, 32'h40);
      for (int i = 0; i < 6; i++) wr(8'h04, 32'(8'hC0 + i));
      repeat (4) @(negedge clk);
      for (int i = 0; i < 6; i++) if (log_a[base+i] !== 8'(8'h40 + i) || log_d[base+i] !== 8'(8'hC0 + i)) bad++;
      tests++;
      if (n_log - base !== 6 || bad != 0) begin fails++; $display("FAIL b2b_writes got n=%0d bad=%0d want 6,0", n_log - base, bad); end
      rd(8'h08, q);
      tests++;
      if (q !== 32'h0000_4606) begin fails++; $display("FAIL b2b_status got %h want 00004606", q); end
   endtask

   task automatic test_flush;
      logic [31:0] q;
      int base;
      wr(8'h0C, 32'h20);
      base = n_log;
      wr(8'h04, 32'h01);
      wr(8'h04, 32'h02);
      wr(8'h00, 32'h0);
      #1;
      tests++;
      if (cpu_rst !== 1'b1 || n_log - base !== 2) begin fails++; $display("FAIL flush_hold got cpu_rst=%b n=%0d want 1,2", cpu_rst, n_log - base); end
      @(negedge clk);
      tests++;
      if (cpu_rst !== 1'b0) begin fails++; $display("FAIL flush_release got %b want 0", cpu_rst); end
      wr(8'h04, 32'h77);
      repeat (3) @(negedge clk);
      rd(8'h08, q);
      tests++;
      if (q !== 32'h0000_2212 || n_log - base !== 2) begin fails++; $display("FAIL run_err got status=%h n=%0d want 00002212,2", q, n_log - base); end
   endtask

   task automatic test_ctrl_clear;
      logic [31:0] q;
      wr(8'h00, 32'h3);
      @(negedge clk);
      tests++;
      if (cpu_rst !== 1'b1) begin fails++; $display("FAIL reload_cpu_rst got %b want 1", cpu_rst); end
      rd(8'h08, q);
      tests++;
      if (q !== 32'h0000_0006) begin fails++; $display("FAIL clear_status got %h want 00000006", q); end
   endtask

   task automatic test_csum;
      logic [31:0] q, exp;
`ifdef JACARANDA_LOADER_CSUM_EN
      exp = 32'h0000_02FD;
`else
      exp = 32'h0;
`endif
      for (int i = 0; i < 3; i++) wr(8'h04, 32'hFF);
      repeat (4) @(negedge clk);
      rd(8'h10, q);
      tests++;
      if (q !== exp) begin fails++; $display("FAIL csum_sum got %h want %h", q, exp); end
      wr(8'h00, 32'h3);
      rd(8'h10, q);
      tests++;
      if (q !== 32'h0) begin fails++; $display("FAIL csum_clear got %h want 0", q); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_ack_timing();
      test_sequential();
      test_wrap();
      test_back_to_back();
      test_flush();
      test_ctrl_clear();
      test_csum();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
